// File: rtl/basemul_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : basemul_sequencer_pkg
//  Brief   : Kyber constants, FSM encoding and step indexing for the
//            degree-2 base-multiplication sequencer.
//  Revision: 1.0  initial release
// ============================================================================
package basemul_sequencer_pkg;

    localparam int KYBER_Q    = 3329;
    localparam int KYBER_QINV = -3327;

    localparam int              c_step_w    = 3;
    localparam logic [2:0]      c_step_last = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/basemul_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module  : basemul_sequencer_if
//  Brief   : Operand input, result output and montgomery_reduce side-channel
//            of the base-multiplication sequencer. slave = the sequencer.
//  Revision: 1.0  initial release
// ============================================================================
interface basemul_sequencer_if;

    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] a0;
    logic signed [15:0] a1;
    logic signed [15:0] b0;
    logic signed [15:0] b1;
    logic signed [15:0] zeta;

    logic signed [31:0] red_a;
    logic               red_set;
    logic signed [15:0] red_t;

    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] r0;
    logic signed [15:0] r1;

    modport slave (
        input  in_valid, a0, a1, b0, b1, zeta, red_t, out_ready,
        output in_ready, red_a, red_set, out_valid, r0, r1
    );

    modport master (
        output in_valid, a0, a1, b0, b1, zeta, red_t, out_ready,
        input  in_ready, red_a, red_set, out_valid, r0, r1
    );

endinterface
`default_nettype wire

// File: rtl/basemul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : basemul_sequencer
//  Brief   : Sequences the five products of a Kyber base multiplication
//            through an external montgomery_reduce and accumulates r0/r1.
//  Revision: 1.0  initial release
// ============================================================================
module basemul_sequencer
    import basemul_sequencer_pkg::*;
#(
    parameter int RED_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    basemul_sequencer_if.slave bus
);

    // WAIT covers the reduce latency beyond the single CAPTURE cycle.
    localparam int                 c_cnt_w     = (RED_LAT > 1) ? $clog2(RED_LAT) : 1;
    localparam logic [c_cnt_w-1:0] c_wait_load = c_cnt_w'(RED_LAT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_step_w-1:0]   r_step;
    logic [c_step_w-1:0]   w_step_nxt;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [c_cnt_w-1:0]    w_cnt_nxt;

    logic signed [15:0]    r_a0;
    logic signed [15:0]    r_a1;
    logic signed [15:0]    r_b0;
    logic signed [15:0]    r_b1;
    logic signed [15:0]    r_zeta;
    logic signed [15:0]    r_t0;
    logic signed [15:0]    r_r0;
    logic signed [15:0]    r_r1;

    logic signed [15:0]    w_mul_x;
    logic signed [15:0]    w_mul_y;
    logic signed [31:0]    w_prod;
    logic                  w_accept;
    logic                  w_capture;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_step  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_step_nxt    = r_step;
        w_cnt_nxt     = r_cnt;
        w_accept      = 1'b0;
        w_capture     = 1'b0;
        bus.in_ready  = 1'b0;
        bus.red_set   = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept    = 1'b1;
                    w_step_nxt  = '0;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                bus.red_set = 1'b1;
                w_cnt_nxt   = c_wait_load;
                w_state_nxt = (RED_LAT > 1) ? ST_WAIT : ST_CAPTURE;
            end
            ST_WAIT: begin
                w_cnt_nxt = r_cnt - c_cnt_one;
                if (r_cnt == c_cnt_one) begin
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_capture = 1'b1;
                if (r_step == c_step_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_step_nxt  = r_step + 3'd1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Single shared multiplier; operand pair chosen by step.
    always_comb begin
        w_mul_x = r_a1;
        w_mul_y = r_b1;
        case (r_step)
            3'd0:    begin w_mul_x = r_a1; w_mul_y = r_b1;   end
            3'd1:    begin w_mul_x = r_t0; w_mul_y = r_zeta; end
            3'd2:    begin w_mul_x = r_a0; w_mul_y = r_b0;   end
            3'd3:    begin w_mul_x = r_a0; w_mul_y = r_b1;   end
            3'd4:    begin w_mul_x = r_a1; w_mul_y = r_b0;   end
            default: begin w_mul_x = r_a1; w_mul_y = r_b1;   end
        endcase
    end

    assign w_prod    = $signed({{16{w_mul_x[15]}}, w_mul_x}) * $signed({{16{w_mul_y[15]}}, w_mul_y});
    assign bus.red_a = (r_state == ST_ISSUE) ? w_prod : 32'sd0;
    assign bus.r0    = r_r0;
    assign bus.r1    = r_r1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a0   <= '0;
            r_a1   <= '0;
            r_b0   <= '0;
            r_b1   <= '0;
            r_zeta <= '0;
            r_t0   <= '0;
            r_r0   <= '0;
            r_r1   <= '0;
        end else begin
            if (w_accept) begin
                r_a0   <= bus.a0;
                r_a1   <= bus.a1;
                r_b0   <= bus.b0;
                r_b1   <= bus.b1;
                r_zeta <= bus.zeta;
            end
            if (w_capture) begin
                case (r_step)
                    3'd0:    r_t0 <= bus.red_t;
                    3'd1:    r_r0 <= bus.red_t;
                    3'd2:    r_r0 <= r_r0 + bus.red_t;
                    3'd3:    r_r1 <= bus.red_t;
                    3'd4:    r_r1 <= r_r1 + bus.red_t;
                    default: r_t0 <= r_t0;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_basemul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_basemul_sequencer
//  Brief   : Directed and random checks of basemul_sequencer against a
//            reference Kyber basemul, with a behavioural montgomery_reduce.
//  Revision: 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_basemul_sequencer;

    typedef struct {
        logic signed [15:0] a0;
        logic signed [15:0] a1;
        logic signed [15:0] b0;
        logic signed [15:0] b1;
        logic signed [15:0] zeta;
        logic signed [15:0] er0;
        logic signed [15:0] er1;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;
    vec_t vecs [6];

    always #5 clk = ~clk;

    basemul_sequencer_if bus ();

    basemul_sequencer #(.RED_LAT(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic signed [15:0] mont(input logic signed [31:0] a);
        logic signed [31:0] p;
        logic signed [15:0] t;
        logic signed [31:0] u;
        p = a * -32'sd3327;
        t = p[15:0];
        u = a - $signed({{16{t[15]}}, t}) * 32'sd3329;
        return u[31:16];
    endfunction

    function automatic logic signed [15:0] fqmul(input logic signed [15:0] x, input logic signed [15:0] y);
        logic signed [31:0] xx;
        logic signed [31:0] yy;
        xx = {{16{x[15]}}, x};
        yy = {{16{y[15]}}, y};
        return mont(xx * yy);
    endfunction

    // Sibling montgomery_reduce: one register stage after the set strobe.
    logic signed [15:0] red_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)            red_q <= '0;
        else if (bus.red_set)  red_q <= mont(bus.red_a);
    end
    assign bus.red_t = red_q;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) check("in_ready_timeout", 0, 1);
    endtask

    task automatic apply(input vec_t v);
        bus.a0   = v.a0;
        bus.a1   = v.a1;
        bus.b0   = v.b0;
        bus.b1   = v.b1;
        bus.zeta = v.zeta;
    endtask

    // One operation: optional busy-time noise on inputs, optional hold of out_ready.
    task automatic do_op(input vec_t v, input bit noise, input int hold, input bit chk_lat);
        int n;
        wait_ready();
        bus.out_ready = (hold == 0);
        apply(v);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = noise;
        check("in_ready_busy", bus.in_ready, 0);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 100) begin
            if (noise && n < 7) begin
                bus.a0 = 16'($urandom_range(0, 6656) - 3328);
                bus.b1 = 16'($urandom_range(0, 6656) - 3328);
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk); #1; n++;
        end
        bus.in_valid = 1'b0;
        if (n >= 100) check("out_valid_timeout", 0, 1);
        if (chk_lat) check("latency", n, 10);
        check("r0", bus.r0, v.er0);
        check("r1", bus.r1, v.er1);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("hold_valid", bus.out_valid, 1);
            check("hold_r0", bus.r0, v.er0);
            check("hold_r1", bus.r1, v.er1);
            check("hold_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("post_out_valid", bus.out_valid, 0);
        check("post_in_ready", bus.in_ready, 1);
    endtask

    initial begin
        vec_t v;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a0 = '0; bus.a1 = '0; bus.b0 = '0; bus.b1 = '0; bus.zeta = '0;

        //                a0     a1    b0  b1  zeta   r0    r1
        vecs[0] = '{ 16'sd2285,  16'sd0,    16'sd1, 16'sd0, 16'sd17,  16'sd1,    16'sd0 };
        vecs[1] = '{ 16'sd0,     16'sd2285, 16'sd0, 16'sd1, 16'sd17, -16'sd456,  16'sd0 };
        vecs[2] = '{ 16'sd1,     16'sd0,    16'sd1, 16'sd0, 16'sd0,   16'sd169,  16'sd0 };
        vecs[3] = '{ 16'sd1,     16'sd0,    16'sd0, 16'sd1, 16'sd0,   16'sd0,    16'sd169 };
        vecs[4] = '{ 16'sd2285,  16'sd2285, 16'sd1, 16'sd1, 16'sd17, -16'sd455,  16'sd2 };
        vecs[5] = '{-16'sd2285,  16'sd0,    16'sd1, 16'sd0, 16'sd0,  -16'sd1,    16'sd0 };

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_red_set", bus.red_set, 0);
        check("rst_r0", bus.r0, 0);
        check("rst_r1", bus.r1, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i], 1'b0, (i == 2) ? 5 : 0, 1'b1);
        end

        // Reset in the middle of step 2.
        wait_ready();
        apply(vecs[0]);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("step2_red_set", bus.red_set, 1);
        check("step2_red_a", bus.red_a, 2285);
        reset = 1'b0;
        #1;
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_red_set", bus.red_set, 0);
        check("midrst_r0", bus.r0, 0);
        check("midrst_r1", bus.r1, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        do_op(vecs[0], 1'b0, 0, 1'b1);

        // Busy-time input noise must be ignored.
        do_op(vecs[4], 1'b1, 0, 1'b1);
        do_op(vecs[1], 1'b1, 2, 1'b1);

        // Random operands against the reference basemul.
        for (int i = 0; i < 1000; i++) begin
            v.a0   = 16'($urandom_range(0, 6656) - 3328);
            v.a1   = 16'($urandom_range(0, 6656) - 3328);
            v.b0   = 16'($urandom_range(0, 6656) - 3328);
            v.b1   = 16'($urandom_range(0, 6656) - 3328);
            v.zeta = 16'($urandom_range(0, 6656) - 3328);
            v.er0  = fqmul(fqmul(v.a1, v.b1), v.zeta) + fqmul(v.a0, v.b0);
            v.er1  = fqmul(v.a0, v.b1) + fqmul(v.a1, v.b0);
            do_op(v, 1'b0, int'($urandom_range(0, 3)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
